// File: rtl/div_scheduler_pkg.sv
// Shared types and defaults for the divider scheduler (state encoding, widths, latency).
package div_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W_DEF  = 20;
  localparam int DIVISOR_W_DEF   = 12;
  localparam int DIV_LATENCY_DEF = 24;

  // Counter only needs to reach DIV_LATENCY-1; keep at least one bit.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// Request arbiter for the shared divider: round-robin when DIV_SCHED_RR_EN is defined,
// otherwise fixed priority (lowest index wins, no pointer register).
module div_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               i_sclr,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

`ifdef DIV_SCHED_RR_EN
  logic [IDX_W-1:0] r_ptr;

  // Scan from the pointer upward with wrap; descending loop lets the nearest hit win.
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req[j]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(j);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (int'(o_idx) == NUM_REQ - 1) ? '0 : o_idx + 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, i_sclr, i_advance};

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end
`endif

endmodule

// File: rtl/div_scheduler.sv
// Shares one fixed-latency divider among NUM_REQ cluster-mean requesters.
// Arbitration policy selected by DIV_SCHED_RR_EN (round-robin) inside div_rr_arbiter.
module div_scheduler
  import div_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DIVIDEND_W  = DIVIDEND_W_DEF,
  parameter int DIVISOR_W   = DIVISOR_W_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DIVIDEND_W-1:0] req_dividend,
  input  logic [NUM_REQ*DIVISOR_W-1:0]  req_divisor,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          done,
  output logic [IDX_W-1:0]              done_idx,
  output logic [DIVIDEND_W-1:0]         result,
  output logic                          div_by_zero,
  output logic                          busy,
  output logic                          div_ce,
  output logic                          div_sclr,
  output logic [DIVIDEND_W-1:0]         div_dividend,
  output logic [DIVISOR_W-1:0]          div_divisor,
  input  logic [DIVIDEND_W-1:0]         div_quotient
);

  localparam int CNT_W = cnt_width(DIV_LATENCY);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_zero;
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_done;
  logic [IDX_W-1:0]      r_done_idx;
  logic [DIVIDEND_W-1:0] r_result;
  logic                  r_div_by_zero;
  logic                  r_busy;
  logic                  r_div_ce;
  logic [DIVIDEND_W-1:0] r_div_dividend;
  logic [DIVISOR_W-1:0]  r_div_divisor;

  logic [NUM_REQ-1:0]    w_win_gnt;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_win_any;
  logic                  w_accept;
  logic [DIVIDEND_W-1:0] w_sel_dividend;
  logic [DIVISOR_W-1:0]  w_sel_divisor;

  // DONE also arbitrates so back-to-back operations start one cycle after done.
  assign w_accept = w_win_any && (r_state == ST_IDLE || r_state == ST_DONE);

  assign w_sel_dividend = req_dividend[int'(w_win_idx)*DIVIDEND_W +: DIVIDEND_W];
  assign w_sel_divisor  = req_divisor[int'(w_win_idx)*DIVISOR_W +: DIVISOR_W];

  div_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk       (clk),
    .i_sclr    (sclr),
    .i_req     (req),
    .i_advance (w_accept),
    .o_gnt     (w_win_gnt),
    .o_idx     (w_win_idx),
    .o_any     (w_win_any)
  );

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_zero         <= 1'b0;
      r_grant        <= '0;
      r_done         <= 1'b0;
      r_done_idx     <= '0;
      r_result       <= '0;
      r_div_by_zero  <= 1'b0;
      r_busy         <= 1'b0;
      r_div_ce       <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
    end else begin
      r_grant <= '0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_grant        <= w_win_gnt;
            r_idx          <= w_win_idx;
            r_div_dividend <= w_sel_dividend;
            r_div_divisor  <= w_sel_divisor;
            r_zero         <= (w_sel_divisor == '0);
            r_cnt          <= '0;
            r_busy         <= 1'b1;
            r_state        <= ST_BUSY;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Grant cycle clears the divider (div_sclr); ce starts the following cycle.
          if (r_zero) begin
            r_result      <= '0;
            r_div_by_zero <= 1'b1;
            r_done        <= 1'b1;
            r_done_idx    <= r_idx;
            r_state       <= ST_DONE;
          end else if (!r_div_ce) begin
            r_div_ce <= 1'b1;
          end else if (r_cnt == CNT_W'(DIV_LATENCY - 1)) begin
            r_result      <= div_quotient;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b1;
            r_done_idx    <= r_idx;
            r_div_ce      <= 1'b0;
            r_state       <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy   <= 1'b0;
          r_div_ce <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign done         = r_done;
  assign done_idx     = r_done_idx;
  assign result       = r_result;
  assign div_by_zero  = r_div_by_zero;
  assign busy         = r_busy;
  assign div_ce       = r_div_ce;
  assign div_sclr     = sclr | (|r_grant);
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;

endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench for div_scheduler with a behavioural divider pipeline (DIV_LATENCY=4).
module tb_div_scheduler;

  localparam int N   = 4;
  localparam int DW  = 20;
  localparam int SW  = 12;
  localparam int LAT = 4;
  localparam int IW  = 2;

  logic            clk;
  logic            sclr;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_dividend;
  logic [N*SW-1:0] req_divisor;
  logic [N-1:0]    grant;
  logic            done;
  logic [IW-1:0]   done_idx;
  logic [DW-1:0]   result;
  logic            div_by_zero;
  logic            busy;
  logic            div_ce;
  logic            div_sclr;
  logic [DW-1:0]   div_dividend;
  logic [SW-1:0]   div_divisor;
  logic [DW-1:0]   div_quotient;

  div_scheduler #(
    .NUM_REQ     (N),
    .DIVIDEND_W  (DW),
    .DIVISOR_W   (SW),
    .DIV_LATENCY (LAT),
    .IDX_W       (IW)
  ) dut (
    .clk          (clk),
    .sclr         (sclr),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .grant        (grant),
    .done         (done),
    .done_idx     (done_idx),
    .result       (result),
    .div_by_zero  (div_by_zero),
    .busy         (busy),
    .div_ce       (div_ce),
    .div_sclr     (div_sclr),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: LAT-1 ce-gated stages, cleared by div_sclr.
  logic [DW-1:0] pipe [LAT-1];
  always @(posedge clk) begin
    if (div_sclr) begin
      for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
    end else if (div_ce) begin
      pipe[0] <= (div_divisor == '0) ? '1 : div_dividend / {{(DW-SW){1'b0}}, div_divisor};
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign div_quotient = pipe[LAT-2];

  typedef struct {
    int            idx;
    logic [DW-1:0] q;
    bit            dbz;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  bit   drop   = 1'b0;

  logic [N-1:0]    req_q;
  logic [N*DW-1:0] dvd_q;
  logic [N*SW-1:0] dvs_q;
  logic            sclr_q;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    req_q  <= req;
    dvd_q  <= req_dividend;
    dvs_q  <= req_divisor;
    sclr_q <= sclr;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef DIV_SCHED_RR_EN
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  // Reference model and per-cycle comparisons.
  initial begin
    bit            m_active = 1'b0;
    bit            m_free   = 1'b1;
    bit            m_zero   = 1'b0;
    int            m_tg     = 0;
    int            m_due    = 0;
    int            m_ptr    = 0;
    logic [DW-1:0] m_res    = '0;
    int            m_idx    = 0;
    bit            m_dbz    = 1'b0;
    logic [DW-1:0] m_dvd    = '0;
    logic [SW-1:0] m_dvs    = '0;
    logic [N-1:0]  eg;
    exp_t          e;
    bit            ed;
    int            w;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        eg = '0;
        if (sclr_q) begin
          sb.delete();
          m_active = 1'b0;
          m_ptr = 0; m_res = '0; m_idx = 0; m_dbz = 1'b0; m_dvd = '0; m_dvs = '0;
        end else if (m_free && req_q != '0) begin
          w = pick(req_q, m_ptr);
          eg[w] = 1'b1;
          m_dvd = dvd_q[w*DW +: DW];
          m_dvs = dvs_q[w*SW +: SW];
          m_zero = (m_dvs == '0);
          m_tg = cyc;
          m_due = cyc + (m_zero ? 1 : LAT + 1);
          m_active = 1'b1;
          e.idx = w;
          e.q = m_zero ? '0 : m_dvd / {{(DW-SW){1'b0}}, m_dvs};
          e.dbz = m_zero;
          e.due = m_due;
          sb.push_back(e);
          m_ptr = (w + 1) % N;
        end else if (m_active && cyc > m_due) begin
          m_active = 1'b0;
        end

        check_eq("grant", grant, eg);
        for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);

        ed = (sb.size() > 0) && (sb[0].due == cyc);
        check_eq("done", done, ed);
        if (ed) begin
          e = sb.pop_front();
          m_res = e.q; m_idx = e.idx; m_dbz = e.dbz;
        end
        check_eq("done_idx", done_idx, m_idx);
        check_eq("result", result, m_res);
        check_eq("div_by_zero", div_by_zero, m_dbz);
        check_eq("busy", busy, m_active && cyc <= m_due);
        check_eq("div_ce", div_ce, m_active && !m_zero && cyc >= m_tg + 1 && cyc <= m_tg + LAT);
        check_eq("div_sclr", div_sclr, sclr | (eg != '0));
        check_eq("div_dividend", div_dividend, m_dvd);
        check_eq("div_divisor", div_divisor, m_dvs);

        m_free = sclr_q ? 1'b1 : (!m_active || cyc == m_due);
      end
    end
  end

  // Requester model: a served requester drops req in the cycle it sees done.
  task automatic tick();
    @(negedge clk);
    if (drop && done) req[done_idx] = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] dvd, input logic [SW-1:0] dvs);
    req_dividend[i*DW +: DW] = dvd;
    req_divisor[i*SW +: SW]  = dvs;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = done;
    end
    if (!seen) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int exp_order[5];
    bit got_gnt;
    sclr = 1'b1;
    req = '0;
    req_dividend = '0;
    req_divisor = '0;
    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    sclr = 1'b0;

    // Single request, 100/7.
    tick();
    set_op(1, 20'd100, 12'd7);
    drop = 1'b1;
    req = 4'b0010;
    repeat (10) tick();
    check_eq("t1_result", result, 20'd14);
    check_eq("t1_idx", done_idx, 1);

    // All four requesting continuously from a fresh reset.
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, DW'(1000 * (i + 1) + i), SW'(3 + i));
    drop = 1'b0;
    glog.delete();
    req = 4'b1111;
    repeat (32) tick();
    req = '0;
    repeat (8) tick();
`ifdef DIV_SCHED_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5; k++)
      check_eq("t2_order", (k < glog.size()) ? glog[k] : -1, exp_order[k]);

    // Zero divisor.
    drop = 1'b1;
    set_op(2, 20'd500, 12'd0);
    req = 4'b0100;
    repeat (5) tick();
    check_eq("t3_result", result, 0);
    check_eq("t3_dbz", div_by_zero, 1);

    // Reset in the middle of an operation, then a fresh pair of requests.
    set_op(0, 20'd777, 12'd5);
    req = 4'b0001;
    got_gnt = 1'b0;
    for (int k = 0; k < 20 && !got_gnt; k++) begin
      tick();
      got_gnt = (grant != '0);
    end
    if (!got_gnt) check_eq("t4_grant_timeout", 0, 1);
    req = '0;
    repeat (2) tick();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    set_op(0, 20'd900, 12'd9);
    set_op(1, 20'd50, 12'd5);
    req = 4'b0011;
    wait_done("t4a");
    check_eq("t4_first_idx", done_idx, 0);
    check_eq("t4_first_result", result, 20'd100);
    wait_done("t4b");
    check_eq("t4_second_idx", done_idx, 1);

    // Operand extremes.
    repeat (2) tick();
    set_op(1, 20'hFFFFF, 12'd1);
    req = 4'b0010;
    wait_done("t5a");
    check_eq("t5_max_result", result, 20'hFFFFF);
    repeat (2) tick();
    set_op(2, 20'd5, 12'hFFF);
    req = 4'b0100;
    wait_done("t5b");
    check_eq("t5_small_result", result, 0);
    check_eq("t5_small_dbz", div_by_zero, 0);

    repeat (4) tick();
    check_eq("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
